pixel_scanner: RTL
==================

# pixel_scanner

Raster-order pixel coordinate source for the ray pipeline. Sits directly upstream of `generate_ray`: walks every pixel of the frame, issuing each coordinate `SAMPLES_PER_PIXEL` times so the downstream jitter PRNG yields distinct sub-pixel samples. Honors the same `stall` back-pressure as `generate_ray` and flags frame start, last beat and frame completion for the accumulator/framebuffer logic.

## Interface

- `PIXEL_WIDTH`, 800, horizontal resolution (1..1024)
- `PIXEL_HEIGHT`, 600, vertical resolution (1..1024)
- `SAMPLES_PER_PIXEL`, 4, consecutive beats per pixel (1..256)

- `clk` in 1: single clock; all state updates on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a frame; sampled only in IDLE
- `stall` in 1: downstream back-pressure; freezes all state and outputs
- `pixel_x` out 10: column, 0..PIXEL_WIDTH-1
- `pixel_y` out 10: row, 0..PIXEL_HEIGHT-1
- `sample_idx` out 8: sample number within current pixel, 0..SAMPLES_PER_PIXEL-1
- `pixel_valid` out 1: current coordinate is a live beat
- `frame_first` out 1: current beat is (0,0,sample 0)
- `frame_last` out 1: current beat is (W-1,H-1,SPP-1)
- `frame_done` out 1: one-cycle pulse after last beat accepted
- `busy` out 1: high in SCAN and DONE

## Operation

- FSM states: IDLE, SCAN, DONE.
- IDLE: outputs idle; `start`=1 on a rising edge -> SCAN, counters at (0,0,0). `stall` does not block start.
- SCAN: `pixel_valid`=1. A beat is accepted on a rising edge with `stall`=0. On acceptance, advance: `sample_idx` first, wrapping to 0 and incrementing `pixel_x`; `pixel_x` wraps at PIXEL_WIDTH-1 and increments `pixel_y`. Acceptance of the `frame_last` beat -> DONE, counters cleared.
- `stall`=1 in SCAN: counters, state and all outputs hold exactly.
- DONE: one cycle, `frame_done`=1, `pixel_valid`=0, then IDLE unconditionally (not affected by stall).
- `start` in SCAN or DONE ignored; it is not queued.
- `frame_first`, `frame_last` decoded from registered counters, qualified by `pixel_valid`. Both high on the same beat when W=H=SPP=1.
- Counters compare against parameter-minus-one constants; no arithmetic beyond +1. Unused upper bits of `sample_idx` zero.

## Timing

- Reset (async assert, sync-safe release): state IDLE; `pixel_x`, `pixel_y`, `sample_idx`=0; `pixel_valid`, `frame_first`, `frame_last`, `frame_done`, `busy`=0.
- Reset mid-frame: immediate abort to reset values; no `frame_done`.
- Start latency: `start` sampled at edge N -> `pixel_valid`=1, `frame_first`=1 after edge N.
- Throughput: one beat per unstalled cycle; frame occupies W*H*SPP unstalled SCAN cycles plus one DONE cycle.
- `frame_done` high in the cycle after the edge accepting the last beat; earliest next `start` acceptance is the edge ending DONE + 1 (IDLE cycle).
- All outputs registered; no combinational path from `stall` or `start` to any output.

## Structure

- Shared package: `PIXEL_WIDTH`, `PIXEL_HEIGHT` defaults, `COORD_W`=10, `SAMPLE_W`=8, and the `scan_state_t` enum, alongside the existing ray typedefs, so `generate_ray` and this block agree on coordinate width.
- One sub-module: `wrap_counter` (parameter MAX; inputs `en`, `clr`; outputs `count`, `at_max`), instantiated three times as a sample -> x -> y carry chain.

## Test plan

Use W=4, H=3, SPP=2 (24 beats) unless noted.
- Reset then `start` pulse, `stall`=0 -> 24 consecutive valid beats in order (0,0,0),(0,0,1),(1,0,0)...(3,2,1); `frame_first` on beat 0 only, `frame_last` on beat 23 only; `frame_done` one cycle later; `busy` low after.
- `stall` high 3 cycles at beat (2,1,1) -> outputs frozen at (2,1,1) for 3 cycles, then resume (3,1,0); total beats still 24, no duplicates or skips.
- `start` pulsed during SCAN and during DONE -> ignored; exactly one frame; second `start` in IDLE starts a fresh frame at (0,0,0).
- `rst_n` asserted at beat 10 -> all outputs 0 asynchronously, no `frame_done`; subsequent `start` restarts at (0,0,0).
- W=H=SPP=1 -> single beat with `frame_first`=`frame_last`=1, then `frame_done`.
- Default params (800x600, SPP=4) with random stall -> 1,920,000 accepted beats, final beat (799,599,3), coordinates always in range.

Source files
------------

// File: rtl/pixel_scanner_pkg.sv
// Shared ray-pipeline types: coordinate widths, frame defaults and scanner states.
// generate_ray and pixel_scanner both import this so coordinate widths stay in step.
package pixel_scanner_pkg;

  localparam int PIXEL_WIDTH       = 800;
  localparam int PIXEL_HEIGHT      = 600;
  localparam int SAMPLES_PER_PIXEL = 4;
  localparam int COORD_W           = 10;
  localparam int SAMPLE_W          = 8;

  typedef logic [COORD_W-1:0]  coord_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  // Per-beat ray request handed to generate_ray.
  typedef struct packed {
    coord_t  x;
    coord_t  y;
    sample_t sample;
  } ray_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/pixel_scanner_wrap_counter.sv
// Up-counter that wraps from MAX back to 0; at_max_o feeds the next stage's enable.
module wrap_counter #(
  parameter int WIDTH = 10,
  parameter int MAX   = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_max_o
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  assign at_max_o = (count_q == MaxVal);
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = at_max_o ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pixel_scanner.sv
// Raster-order pixel coordinate source: every pixel issued SAMPLES_PER_PIXEL times,
// frozen by stall, with frame first/last/done flags for the accumulator.
//
// state | meaning
// IDLE  | waiting for start, outputs idle
// SCAN  | issuing beats, one per unstalled cycle
// DONE  | one-cycle frame_done pulse, then back to IDLE
module pixel_scanner #(
  parameter int PIXEL_WIDTH       = pixel_scanner_pkg::PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT      = pixel_scanner_pkg::PIXEL_HEIGHT,
  parameter int SAMPLES_PER_PIXEL = pixel_scanner_pkg::SAMPLES_PER_PIXEL
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic                                 stall_i,
  output logic [pixel_scanner_pkg::COORD_W-1:0]  pixel_x_o,
  output logic [pixel_scanner_pkg::COORD_W-1:0]  pixel_y_o,
  output logic [pixel_scanner_pkg::SAMPLE_W-1:0] sample_idx_o,
  output logic                                 pixel_valid_o,
  output logic                                 frame_first_o,
  output logic                                 frame_last_o,
  output logic                                 frame_done_o,
  output logic                                 busy_o
);

  import pixel_scanner_pkg::*;

  scan_state_t state_q, state_d;

  logic                accept;
  logic                cnt_clr;
  logic                s_max, x_max, y_max;
  logic                last_beat;
  logic [SAMPLE_W-1:0] s_cnt;
  logic [COORD_W-1:0]  x_cnt, y_cnt;

  assign accept    = (state_q == SCAN) && !stall_i;
  assign cnt_clr   = (state_q != SCAN);
  assign last_beat = s_max && x_max && y_max;

  // Carry chain: sample -> x -> y. The last beat wraps all three back to zero.
  wrap_counter #(.WIDTH(SAMPLE_W), .MAX(SAMPLES_PER_PIXEL - 1)) u_sample (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (accept),
    .clr_i    (cnt_clr),
    .count_o  (s_cnt),
    .at_max_o (s_max)
  );

  wrap_counter #(.WIDTH(COORD_W), .MAX(PIXEL_WIDTH - 1)) u_x (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (accept && s_max),
    .clr_i    (cnt_clr),
    .count_o  (x_cnt),
    .at_max_o (x_max)
  );

  wrap_counter #(.WIDTH(COORD_W), .MAX(PIXEL_HEIGHT - 1)) u_y (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (accept && s_max && x_max),
    .clr_i    (cnt_clr),
    .count_o  (y_cnt),
    .at_max_o (y_max)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pixel_valid_o = 1'b0;
    frame_first_o = 1'b0;
    frame_last_o  = 1'b0;
    frame_done_o  = 1'b0;
    busy_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = SCAN;
      end
      SCAN: begin
        pixel_valid_o = 1'b1;
        busy_o        = 1'b1;
        frame_first_o = (s_cnt == '0) && (x_cnt == '0) && (y_cnt == '0);
        frame_last_o  = last_beat;
        if (accept && last_beat) state_d = DONE;
      end
      DONE: begin
        frame_done_o = 1'b1;
        busy_o       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pixel_x_o    = x_cnt;
  assign pixel_y_o    = y_cnt;
  assign sample_idx_o = s_cnt;

endmodule
